// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: fetches one 16-byte line (four 32-bit beats) on an I-cache miss and writes it back.
// Optional build macro ICACHE_REFILL_PERF_EN adds a saturating miss_count output.
module icache_refill_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ifetch_req,
    input  logic [31:0]  ifetch_addr,
    input  logic         cache_hit,
    output logic         stall,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata,
    output logic         fill_we,
    output logic [31:0]  fill_addr,
    output logic [127:0] fill_line,
    output logic         err
`ifdef ICACHE_REFILL_PERF_EN
   ,output logic [31:0]  miss_count
`endif
);
    localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, BEAT, FILL} state_t;

    state_t        state;
    logic [1:0]    beat;
    logic [WW-1:0] wait_cnt;
    logic          miss;
    logic          expired;

    assign miss    = ifetch_req & ~cache_hit;
    // a zero TIMEOUT parameter removes the abort path entirely
    assign expired = (TIMEOUT > 0) && (wait_cnt == WLAST);
    assign stall   = (state == IDLE) ? miss : 1'b1;

    // refill sequencer; mem_addr doubles as the latched line base for the whole refill
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            beat      <= '0;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            fill_we   <= 1'b0;
            fill_addr <= '0;
            fill_line <= '0;
            err       <= 1'b0;
        end else begin
            fill_we <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: if (miss) begin
                    state    <= REQ;
                    mem_req  <= 1'b1;
                    mem_addr <= ifetch_addr & 32'hFFFF_FFF0;
                    wait_cnt <= '0;
                end
                REQ: if (mem_gnt) begin
                    state    <= BEAT;
                    mem_req  <= 1'b0;
                    beat     <= '0;
                    wait_cnt <= '0;
                end else if (expired) begin
                    state     <= IDLE;
                    mem_req   <= 1'b0;
                    err       <= 1'b1;
                    fill_line <= '0;
                    wait_cnt  <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                BEAT: if (mem_rvalid) begin
                    fill_line[{beat, 5'b0} +: 32] <= mem_rdata;
                    beat     <= beat + 2'd1;
                    wait_cnt <= '0;
                    if (beat == 2'd3) begin
                        state     <= FILL;
                        fill_we   <= 1'b1;
                        fill_addr <= mem_addr;
                    end
                end else if (expired) begin
                    state     <= IDLE;
                    err       <= 1'b1;
                    fill_line <= '0;
                    beat      <= '0;
                    wait_cnt  <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                FILL: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_REFILL_PERF_EN
    // saturating count of misses that start a refill
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) miss_count <= '0;
        else if (state == IDLE && miss && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized self-checking bench for icache_refill_ctrl (TIMEOUT=8).
module tb_icache_refill_ctrl;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         ifetch_req = 1'b0;
    logic [31:0]  ifetch_addr = '0;
    logic         cache_hit = 1'b0;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         fill_we;
    logic [31:0]  fill_addr;
    logic [127:0] fill_line;
    logic         err;
`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0]  miss_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_miss = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
        .cache_hit(cache_hit), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_addr(fill_addr), .fill_line(fill_line), .err(err)
`ifdef ICACHE_REFILL_PERF_EN
       ,.miss_count(miss_count)
`endif
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // one miss refill: gd = REQ cycles without grant, gN = idle cycles before beat N
    task automatic do_refill(input string name, input logic [31:0] addr, input int gd,
                             input int g0, input int g1, input int g2, input int g3,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3, input logic noise);
        int gaps[4];
        logic [31:0] d[4];
        int bc[4];
        int fc, we_cnt, we_at, req_cnt;
        logic [127:0] got_line, exp_line;
        logic [31:0] got_faddr, base;
        logic exp_req, exp_stall, beat_now;
        gaps = '{g0, g1, g2, g3};
        d = '{d0, d1, d2, d3};
        base = {addr[31:4], 4'h0};
        exp_line = {d[3], d[2], d[1], d[0]};
        bc[0] = gd + 2 + gaps[0];
        for (int j = 1; j < 4; j++) bc[j] = bc[j-1] + 1 + gaps[j];
        fc = bc[3] + 1;
        we_cnt = 0; we_at = -1; req_cnt = 0;
        got_line = '0; got_faddr = '0;
        for (int c = 0; c <= fc + 1; c++) begin
            if (c == 0) begin
                ifetch_req = 1'b1; cache_hit = 1'b0; ifetch_addr = addr;
            end else if (c <= fc && noise) begin
                ifetch_req = 1'($urandom); cache_hit = 1'($urandom); ifetch_addr = $urandom;
            end else begin
                ifetch_req = 1'b0; cache_hit = 1'b0;
            end
            beat_now = 1'b0;
            for (int j = 0; j < 4; j++) if (c == bc[j]) begin
                beat_now = 1'b1;
                mem_rdata = d[j];
            end
            if (beat_now) mem_rvalid = 1'b1;
            else if (noise && (c <= gd + 1 || c >= fc)) begin
                mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            end else mem_rvalid = 1'b0;
            mem_gnt = (c == gd + 1) ? 1'b1 : (noise && c > gd + 1) ? 1'($urandom) : 1'b0;
            #1;
            exp_stall = (c <= fc);
            exp_req = (c >= 1 && c <= gd + 1);
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL %s stall c=%0d: got %b expected %b", name, c, stall, exp_stall);
            end
            checks++;
            if (mem_req !== exp_req) begin
                errors++;
                $display("FAIL %s mem_req c=%0d: got %b expected %b", name, c, mem_req, exp_req);
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== base) begin
                    errors++;
                    $display("FAIL %s mem_addr: got %h expected %h", name, mem_addr, base);
                end
            end
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL %s err c=%0d: got %b expected 0", name, c, err);
            end
            if (mem_req) req_cnt++;
            if (fill_we) begin
                we_cnt++; we_at = c; got_line = fill_line; got_faddr = fill_addr;
            end
            next_cycle();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        exp_miss++;
        checks++;
        if (req_cnt !== gd + 1) begin
            errors++;
            $display("FAIL %s mem_req cycles: got %0d expected %0d", name, req_cnt, gd + 1);
        end
        checks++;
        if (we_cnt !== 1 || we_at !== fc) begin
            errors++;
            $display("FAIL %s fill_we: got %0d pulses at %0d expected 1 at %0d", name, we_cnt, we_at, fc);
        end
        checks++;
        if (got_line !== exp_line) begin
            errors++;
            $display("FAIL %s fill_line: got %h expected %h", name, got_line, exp_line);
        end
        checks++;
        if (got_faddr !== base) begin
            errors++;
            $display("FAIL %s fill_addr: got %h expected %h", name, got_faddr, base);
        end
    endtask

    task automatic test_reset;
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({mem_req, fill_we, err, stall} !== 4'b0) begin
            errors++;
            $display("FAIL reset flags: got %b expected 0000", {mem_req, fill_we, err, stall});
        end
        checks++;
        if (mem_addr !== '0 || fill_addr !== '0 || fill_line !== '0) begin
            errors++;
            $display("FAIL reset data: got %h %h %h expected zeros", mem_addr, fill_addr, fill_line);
        end
        ifetch_req = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL reset stall comb: got %b expected 1", stall);
        end
        ifetch_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        exp_miss = 0;
        next_cycle();
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset release: got req=%b stall=%b expected 0 0", mem_req, stall);
        end
    endtask

    task automatic test_hit;
        for (int i = 0; i < 8; i++) begin
            ifetch_req = (i < 7);
            cache_hit = 1'b1;
            ifetch_addr = (i == 0) ? 32'h4 : $urandom;
            mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom);
            #1;
            checks++;
            if (stall !== 1'b0 || mem_req !== 1'b0 || fill_we !== 1'b0) begin
                errors++;
                $display("FAIL hit c=%0d: got stall=%b req=%b we=%b expected 0 0 0", i, stall, mem_req, fill_we);
            end
            next_cycle();
        end
        ifetch_req = 1'b0; cache_hit = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_timeout;
        logic exp_req, exp_err;
        int err_cnt = 0;
        for (int c = 0; c <= TO + 4; c++) begin
            ifetch_req = (c == 0); cache_hit = 1'b0; ifetch_addr = 32'h20;
            mem_gnt = 1'b0; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
            #1;
            exp_req = (c >= 1 && c <= TO);
            exp_err = (c == TO + 1);
            checks++;
            if (mem_req !== exp_req || err !== exp_err || fill_we !== 1'b0) begin
                errors++;
                $display("FAIL timeout c=%0d: got req=%b err=%b we=%b expected %b %b 0",
                         c, mem_req, err, fill_we, exp_req, exp_err);
            end
            checks++;
            if (stall !== (c <= TO)) begin
                errors++;
                $display("FAIL timeout stall c=%0d: got %b expected %b", c, stall, c <= TO);
            end
            if (err) err_cnt++;
            next_cycle();
        end
        mem_rvalid = 1'b0;
        exp_miss++;
        checks++;
        if (err_cnt !== 1) begin
            errors++;
            $display("FAIL timeout err pulses: got %0d expected 1", err_cnt);
        end
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 4; c++) begin
            ifetch_req = (c == 0); cache_hit = 1'b0; ifetch_addr = 32'h30;
            mem_gnt = (c == 1);
            mem_rvalid = (c >= 2);
            mem_rdata = $urandom;
            next_cycle();
        end
        exp_miss++;
        rstn = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        exp_miss = 0;
        checks++;
        if ({mem_req, fill_we, err, stall} !== 4'b0 || mem_addr !== '0 || fill_addr !== '0 || fill_line !== '0) begin
            errors++;
            $display("FAIL reset_mid: got flags=%b ma=%h fa=%h line=%h expected zeros",
                     {mem_req, fill_we, err, stall}, mem_addr, fill_addr, fill_line);
        end
        next_cycle();
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = $urandom;
            next_cycle();
            checks++;
            if (fill_we !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid after: got we=%b req=%b expected 0 0", fill_we, mem_req);
            end
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        do_refill("after_reset_0x40", 32'h40, $urandom_range(0, 3), 0, 1, 0, 2,
                  $urandom, $urandom, $urandom, $urandom, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            do_refill("random", $urandom, $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(0, 4), $urandom, $urandom, $urandom, $urandom, 1'b1);
            test_hit();
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        do_refill("miss_0x07", 32'h7, 0, 0, 0, 0, 0,
                  32'hEFEFEFEF, 32'hCDCDCDCD, 32'hABABABAB, 32'hDEADBEEF, 1'b0);
        do_refill("miss_0x1C", 32'h1C, 3, 0, 1, 0, 0,
                  32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0);
        test_timeout();
        test_reset_mid();
        test_random();
`ifdef ICACHE_REFILL_PERF_EN
        checks++;
        if (miss_count !== 32'(exp_miss)) begin
            errors++;
            $display("FAIL miss_count: got %0d expected %0d", miss_count, exp_miss);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum idle cycles waiting on memory before abort; 0 disables the timeout.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port ifetch_req  input  1  SHALL mean the fetch stage presents a valid address this cycle.
REQ-005 Port ifetch_addr  input  32  SHALL be the fetch byte address.
REQ-006 Port cache_hit  input  1  SHALL be the instruction-cache hit flag for ifetch_addr.
REQ-007 Port stall  output  1  SHALL freeze the fetch stage while high.
REQ-008 Port mem_req  output  1  SHALL request a line read from instruction memory.
REQ-009 Port mem_addr  output  32  SHALL carry the 16-byte-aligned line base address.
REQ-010 Port mem_gnt  input  1  SHALL acknowledge mem_req.
REQ-011 Port mem_rvalid  input  1  SHALL qualify one 32-bit read beat.
REQ-012 Port mem_rdata  input  32  SHALL carry the read beat.
REQ-013 Port fill_we  output  1  SHALL write one line into the cache.
REQ-014 Port fill_addr  output  32  SHALL be the line base address being written.
REQ-015 Port fill_line  output  128  SHALL be the assembled line.
REQ-016 Port err  output  1  SHALL pulse one cycle on memory timeout.

Function
REQ-017 FSM states SHALL be IDLE, REQ, BEAT, FILL.
REQ-018 IDLE: ifetch_req=1 and cache_hit=0 sampled SHALL latch ifetch_addr[31:4],4'b0 as line base and move to REQ.
REQ-019 stall SHALL be (ifetch_req & ~cache_hit) combinationally in IDLE and 1 in REQ, BEAT, FILL.
REQ-020 REQ: mem_req=1 and mem_addr=line base SHALL hold until mem_gnt sampled 1, then move to BEAT with beat counter 0; mem_req low from the next cycle.
REQ-021 BEAT: each cycle with mem_rvalid=1 SHALL store mem_rdata at fill_line[32k+31:32k] (k = beat counter 0..3, byte address base+4k) and increment k; the 4th beat SHALL move to FILL.
REQ-022 mem_rvalid in IDLE/REQ/FILL and mem_gnt outside REQ SHALL be ignored.
REQ-023 FILL: fill_we=1 for exactly one cycle with fill_addr=line base, then IDLE; fill_we SHALL never assert otherwise.
REQ-024 Minimum miss-to-fill_we latency SHALL be 6 cycles (gnt same cycle as entering REQ, four back-to-back beats).
REQ-025 Changes on ifetch_addr, ifetch_req, cache_hit outside IDLE SHALL not affect the refill in progress.
REQ-026 With TIMEOUT>0, a wait counter SHALL clear on entering REQ and on each mem_gnt/mem_rvalid acceptance, increment otherwise in REQ/BEAT, and on reaching TIMEOUT SHALL pulse err, drop mem_req, discard the partial line, return to IDLE.
REQ-027 Address bits [3:0] of mem_addr and fill_addr SHALL always be 0.

Reset
REQ-028 rstn low SHALL immediately force IDLE, beat and wait counters 0, mem_req=0, fill_we=0, err=0, mem_addr=0, fill_addr=0, fill_line=0.
REQ-029 Reset mid-refill SHALL discard the partial line with no fill_we.
REQ-030 stall after reset SHALL follow REQ-019 IDLE rule only.

Configuration
REQ-031 With ICACHE_REFILL_PERF_EN defined, output miss_count (32) SHALL increment on every IDLE->REQ transition, saturate at 32'hFFFFFFFF, reset to 0.
REQ-032 Without ICACHE_REFILL_PERF_EN, port miss_count and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 Hit: ifetch_req=1, cache_hit=1, addr 0x4 -> stall=0, mem_req never asserts.
REQ-034 Miss at 0x7, gnt immediately, beats EFEFEFEF,CDCDCDCD,ABABABAB,DEADBEEF back-to-back -> mem_addr=0x0, fill_we one cycle, fill_line=DEADBEEF_ABABABAB_CDCDCDCD_EFEFEFEF, 6 cycles latency.
REQ-035 Miss at 0x1C, gnt after 3 cycles, one-cycle gap between beats 1 and 2 -> mem_req held 4 cycles, fill_addr=0x10, correct line, stall high until back in IDLE.
REQ-036 TIMEOUT=8, miss at 0x20, gnt never -> err pulses once 8 cycles into REQ, no fill_we, FSM IDLE.
REQ-037 Miss at 0x30, rstn low after 2 beats -> outputs zero at once, no fill_we; next miss at 0x40 refills cleanly.
REQ-038 ICACHE_REFILL_PERF_EN defined, three misses and two hits -> miss_count=3.
